// File: rtl/soc_system_pio_output_stamp.sv
// Avalon-MM output PIO that timestamps the fabric acknowledge of each output update.
// Measures cycles from a DATA/SET/CLEAR write to the next ack_in rising edge, with optional timeout.
module soc_system_pio_output_stamp #(
   parameter int unsigned WIDTH       = 32,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   input  logic             ack_in
);

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_SET     = 3'd1;
   localparam logic [2:0] ADDR_CLEAR   = 3'd2;
   localparam logic [2:0] ADDR_LATENCY = 3'd3;
   localparam logic [2:0] ADDR_STATUS  = 3'd4;
   localparam logic [2:0] ADDR_TIMEOUT = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t           state_q, state_nxt_c;
   logic [WIDTH-1:0] data_q;
   logic [31:0]      latency_q;
   logic [31:0]      timeout_q;
   logic [31:0]      cnt_q;
   logic             done_q;
   logic             tmo_flag_q;
   logic             ack_d;

   logic             wr_c;
   logic             data_wr_c;
   logic             ack_rise_c;
   logic             to_hit_c;
   logic             cnt_load_c;
   logic             cnt_inc_c;
   logic             lat_done_c;
   logic             lat_to_c;
   logic [WIDTH-1:0] wd_c;

   assign wr_c       = chipselect & ~write_n;
   assign data_wr_c  = wr_c & ((address == ADDR_DATA) | (address == ADDR_SET) | (address == ADDR_CLEAR));
   assign ack_rise_c = ack_in & ~ack_d;
   assign to_hit_c   = (timeout_q != 32'h0) && (cnt_q == timeout_q);
   assign wd_c       = writedata[WIDTH-1:0];
   assign out_port   = data_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_nxt_c;
   end

   // Next-state: an output write restarts the measurement from any state
   always_comb begin
      state_nxt_c = state_q;
      if (data_wr_c) begin
         state_nxt_c = S_WAIT;
      end else if (state_q == S_WAIT) begin
         if (ack_rise_c)    state_nxt_c = S_DONE;
         else if (to_hit_c) state_nxt_c = S_IDLE;
      end
   end

   // FSM outputs: counter control and measurement result strobes
   always_comb begin
      cnt_load_c = data_wr_c;
      cnt_inc_c  = 1'b0;
      lat_done_c = 1'b0;
      lat_to_c   = 1'b0;
      if (!data_wr_c && (state_q == S_WAIT)) begin
         cnt_inc_c = 1'b1;
         if (ack_rise_c)    lat_done_c = 1'b1;
         else if (to_hit_c) lat_to_c   = 1'b1;
      end
   end

   // Register file, counter and acknowledge edge detector
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q     <= WIDTH'(RESET_VALUE);
         latency_q  <= 32'h0;
         timeout_q  <= 32'h0;
         cnt_q      <= 32'h0;
         done_q     <= 1'b0;
         tmo_flag_q <= 1'b0;
         ack_d      <= 1'b0;
      end else begin
         ack_d <= ack_in;

         if (wr_c) begin
            case (address)
               ADDR_DATA:    data_q    <= wd_c;
               ADDR_SET:     data_q    <= data_q | wd_c;
               ADDR_CLEAR:   data_q    <= data_q & ~wd_c;
               ADDR_TIMEOUT: timeout_q <= writedata;
               default: ;
            endcase
         end

         if (cnt_load_c)                          cnt_q <= 32'h1;
         else if (cnt_inc_c && (cnt_q != '1))     cnt_q <= cnt_q + 32'h1;

         if (lat_done_c)     latency_q <= cnt_q;
         else if (lat_to_c)  latency_q <= 32'hFFFF_FFFF;

         // Set beats a coincident write-1-clear
         if (lat_done_c)                                              done_q <= 1'b1;
         else if (wr_c && (address == ADDR_STATUS) && writedata[1])   done_q <= 1'b0;

         if (lat_to_c)                                                tmo_flag_q <= 1'b1;
         else if (wr_c && (address == ADDR_STATUS) && writedata[2])   tmo_flag_q <= 1'b0;
      end
   end

   // Read mux, loaded every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= 32'h0;
      end else begin
         case (address)
            ADDR_DATA:    readdata <= 32'(data_q);
            ADDR_LATENCY: readdata <= latency_q;
            ADDR_STATUS:  readdata <= {29'h0, tmo_flag_q, done_q, (state_q == S_WAIT)};
            ADDR_TIMEOUT: readdata <= timeout_q;
            default:      readdata <= 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_soc_system_pio_output_stamp.sv
// Directed bench for soc_system_pio_output_stamp: register-map vector table plus latency/timeout sequences.
module tb_soc_system_pio_output_stamp;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] out_port;
   logic        ack_in;

   int checks   = 0;
   int failures = 0;

   soc_system_pio_output_stamp #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .ack_in     (ack_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cs;
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] wd;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [31:0] exp_out;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic cs, input logic wr, input logic [2:0] addr,
                               input logic [31:0] wd, input logic chk_rd,
                               input logic [31:0] exp_rd, input logic [31:0] exp_out);
      vec_t v;
      v.cs = cs; v.wr = wr; v.addr = addr; v.wd = wd;
      v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_out = exp_out;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the write edge
   task automatic do_write(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic do_read(input logic [2:0] a, output logic [31:0] d);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   logic [31:0] rd;

   initial begin
      reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'h0; ack_in = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_readdata", readdata, 32'h0);
      check("reset_out_port", out_port, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(1'b0, 1'b0, 3'(i), 32'h0, 1'b1, 32'h0, 32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 3'd5, 32'h7,         1'b0, 32'h0,  32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd5, 32'h0,         1'b1, 32'h7,  32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 3'd5, 32'h0,         1'b0, 32'h0,  32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd5, 32'h0,         1'b1, 32'h0,  32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 3'd3, 32'h1234,      1'b0, 32'h0,  32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd3, 32'h0,         1'b1, 32'h0,  32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 1'b0, 32'h0,  32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 3'd6, 32'h0,         1'b1, 32'h0,  32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 3'd0, 32'hF0,        1'b0, 32'h0,  32'hF0));
      vecs.push_back(mk(1'b1, 1'b1, 3'd1, 32'h0F,        1'b0, 32'h0,  32'hFF));
      vecs.push_back(mk(1'b1, 1'b1, 3'd2, 32'h30,        1'b0, 32'h0,  32'hCF));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,         1'b1, 32'hCF, 32'hCF));
      vecs.push_back(mk(1'b0, 1'b0, 3'd4, 32'h0,         1'b1, 32'h1,  32'hCF));
      vecs.push_back(mk(1'b0, 1'b0, 3'd1, 32'h0,         1'b1, 32'h0,  32'hCF));
      vecs.push_back(mk(1'b0, 1'b0, 3'd2, 32'h0,         1'b1, 32'h0,  32'hCF));
      vecs.push_back(mk(1'b0, 1'b1, 3'd0, 32'hFFFF,      1'b0, 32'h0,  32'hCF));
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,         1'b1, 32'hCF, 32'hCF));

      foreach (vecs[i]) begin
         address = vecs[i].addr; writedata = vecs[i].wd;
         chipselect = vecs[i].cs; write_n = ~vecs[i].wr;
         @(negedge clk);
         chipselect = 1'b0; write_n = 1'b1;
         if (vecs[i].chk_rd) check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
         check($sformatf("vec%0d_out_port", i), out_port, vecs[i].exp_out);
      end

      // Ack first sampled 5 edges after the write edge
      do_write(3'd0, 32'h11);
      check("lat5_out_port", out_port, 32'h11);
      repeat (4) @(negedge clk);
      ack_in = 1'b1;
      @(negedge clk);
      ack_in = 1'b0;
      do_read(3'd3, rd); check("lat5_latency", rd, 32'd5);
      do_read(3'd4, rd); check("lat5_status", rd, 32'h2);
      do_write(3'd4, 32'h2);
      do_read(3'd4, rd); check("lat5_status_cleared", rd, 32'h0);

      // Timeout after 10 counts
      do_write(3'd5, 32'd10);
      do_write(3'd0, 32'h22);
      repeat (9) @(negedge clk);
      do_read(3'd4, rd); check("tmo_busy_before", rd, 32'h1);
      do_read(3'd3, rd); check("tmo_latency", rd, 32'hFFFF_FFFF);
      do_read(3'd4, rd); check("tmo_status", rd, 32'h4);
      ack_in = 1'b1;
      repeat (2) @(negedge clk);
      ack_in = 1'b0;
      @(negedge clk);
      do_read(3'd4, rd); check("tmo_status_after_ack", rd, 32'h4);
      do_read(3'd3, rd); check("tmo_latency_after_ack", rd, 32'hFFFF_FFFF);
      do_write(3'd4, 32'h4);
      do_write(3'd5, 32'h0);
      do_read(3'd4, rd); check("tmo_status_cleared", rd, 32'h0);

      // Write coinciding with an ack edge restarts the measurement
      do_write(3'd0, 32'h33);
      repeat (2) @(negedge clk);
      ack_in = 1'b1;
      do_write(3'd0, 32'h44);
      ack_in = 1'b0;
      check("restart_out_port", out_port, 32'h44);
      do_read(3'd3, rd); check("restart_latency_kept", rd, 32'hFFFF_FFFF);
      address = 3'd4;
      @(negedge clk);
      check("restart_busy", readdata, 32'h1);
      ack_in = 1'b1;
      @(negedge clk);
      ack_in = 1'b0;
      do_read(3'd3, rd); check("restart_latency3", rd, 32'd3);
      do_read(3'd4, rd); check("restart_status", rd, 32'h2);

      // Done set wins over a coincident write-1-clear
      do_write(3'd4, 32'h2);
      do_read(3'd4, rd); check("setwin_pre", rd, 32'h0);
      do_write(3'd0, 32'h55);
      ack_in = 1'b1;
      do_write(3'd4, 32'h2);
      ack_in = 1'b0;
      do_read(3'd4, rd); check("setwin_status", rd, 32'h2);
      do_read(3'd3, rd); check("setwin_latency", rd, 32'd1);

      // Reset during WAIT, with a simultaneous write
      do_write(3'd0, 32'hAA);
      check("rst_pre_out_port", out_port, 32'hAA);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      do_write(3'd0, 32'h55);
      check("rst_readdata", readdata, 32'h0);
      check("rst_out_port", out_port, 32'h0);
      reset = 1'b0;
      ack_in = 1'b1;
      repeat (2) @(negedge clk);
      ack_in = 1'b0;
      do_read(3'd4, rd); check("rst_status", rd, 32'h0);
      do_read(3'd3, rd); check("rst_latency", rd, 32'h0);
      check("rst_out_port_after", out_port, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
